// File: rtl/ts_lane_gen.sv
// Multi-lane PCIe TS1/TS2 generator: streams one training-sequence beat per cycle
// under valid/ready and reports when enough beats were accepted. Optional: TS_LANE_REVERSE_EN.
module ts_lane_gen #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ts_req,
  input  logic                       ts_stop,
  input  logic                       ts_type,
  input  logic                       link_pad,
  input  logic [7:0]                 link_num,
  input  logic                       lane_pad,
  input  logic [5:0]                 rate_support,
  input  logic [CNT_W-1:0]           ts_target,
`ifdef TS_LANE_REVERSE_EN
  input  logic                       lane_rev,
`endif
  input  logic                       ts_ready,
  output logic                       ts_valid,
  output logic [NUM_LANES*128-1:0]   ts,
  output logic [CNT_W-1:0]           ts_cnt,
  output logic                       ts_sent_enough,
  output logic                       busy
);

  localparam int unsigned TS_W  = NUM_LANES * 128;
  localparam int unsigned LANE_W = 128;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    STOP_WAIT = 2'd2
  } state_t;

  // Symbol-affecting configuration captured at a request
  typedef struct packed {
    logic       ts_type;
    logic       link_pad;
    logic [7:0] link_num;
    logic       lane_pad;
    logic [5:0] rate;
`ifdef TS_LANE_REVERSE_EN
    logic       lane_rev;
`endif
  } sym_cfg_t;

  state_t           state_q, state_d;
  logic             pend_q, pend_d;
  logic             load, reload, capture, accept;
  logic             armed_q;
  sym_cfg_t         cfg_in, pend_cfg_q, load_cfg;
  logic [CNT_W-1:0] pend_tgt_q, tgt_q, load_tgt;

  function automatic logic [TS_W-1:0] build_ts(input sym_cfg_t c);
    logic [TS_W-1:0] v;
    logic [7:0]      fill;
    logic [7:0]      lane_sym;
    logic [7:0]      link_sym;
    v        = '0;
    fill     = c.ts_type ? 8'h45 : 8'h4A;
    link_sym = c.link_pad ? 8'hF7 : c.link_num;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      lane_sym = 8'(i);
`ifdef TS_LANE_REVERSE_EN
      if (c.lane_rev) lane_sym = 8'(int'(NUM_LANES) - 1 - i);
`endif
      if (c.lane_pad) lane_sym = 8'hF7;
      v[i*LANE_W +: LANE_W] = {8'hBC, link_sym, lane_sym, 8'hFF,
                               {2'b00, c.rate}, 8'h00, {10{fill}}};
    end
    return v;
  endfunction

  always_comb begin
    cfg_in          = '0;
    cfg_in.ts_type  = ts_type;
    cfg_in.link_pad = link_pad;
    cfg_in.link_num = link_num;
    cfg_in.lane_pad = lane_pad;
    cfg_in.rate     = rate_support;
`ifdef TS_LANE_REVERSE_EN
    cfg_in.lane_rev = lane_rev;
`endif
  end

  assign accept   = ts_valid & ts_ready;
  assign load_cfg = reload ? pend_cfg_q : cfg_in;
  assign load_tgt = reload ? pend_tgt_q : ts_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Next state and load control; stop outranks a simultaneous request
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    load    = 1'b0;
    reload  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (ts_req) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (ts_stop) begin
          pend_d  = 1'b0;
          state_d = accept ? IDLE : STOP_WAIT;
        end else begin
          if (accept && pend_q) begin
            reload = 1'b1;
            pend_d = 1'b0;
          end
          if (ts_req) begin
            capture = 1'b1;
            pend_d  = 1'b1;
          end
        end
      end
      STOP_WAIT: begin
        if (accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending configuration waits for the current beat to be accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cfg_q <= '0;
      pend_tgt_q <= '0;
    end else if (capture) begin
      pend_cfg_q <= cfg_in;
      pend_tgt_q <= ts_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_valid       <= 1'b0;
      busy           <= 1'b0;
      ts             <= '0;
      ts_cnt         <= '0;
      ts_sent_enough <= 1'b0;
      tgt_q          <= '0;
      armed_q        <= 1'b0;
    end else begin
      ts_valid <= (state_d != IDLE);
      busy     <= (state_d != IDLE);
      if (load || reload) begin
        ts             <= build_ts(load_cfg);
        tgt_q          <= load_tgt;
        ts_cnt         <= '0;
        ts_sent_enough <= 1'b0;
        armed_q        <= 1'b1;
      end else begin
        if (accept && (ts_cnt != '1)) ts_cnt <= ts_cnt + CNT_W'(1);
        // Sticky until the next load; unarmed after reset so it stays low
        if (armed_q && (ts_cnt >= tgt_q)) ts_sent_enough <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ts_lane_gen.md
Name: ts_lane_gen

Overview:
Parametrised multi-lane PCIe training-sequence generator for the LTSSM model.
- Builds one 16-symbol TS1 or TS2 per lane per beat, with per-lane lane-number fields and a runtime link number.
- Streams beats to the TX FIFO under valid/ready backpressure.
- Counts accepted beats against a runtime target and reports "sent enough" to the LTSSM.

Parameters:
NUM_LANES, 4, lane count (1..16); bus width is NUM_LANES*128.
CNT_W, 16, width of beat counter and target.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ts_req  in  1  pulse: capture config below, (re)start transmission
ts_stop  in  1  pulse: end transmission
ts_type  in  1  0 = TS1, 1 = TS2
link_pad  in  1  1 = link field is PAD
link_num  in  8  link number used when link_pad = 0
lane_pad  in  1  1 = lane field is PAD
rate_support  in  6  data-rate bits for symbol 4
ts_target  in  CNT_W  accepted beats required before ts_sent_enough
ts_ready  in  1  TX FIFO can accept (= not full)
ts_valid  out  1  beat valid
ts  out  NUM_LANES*128  lane i at [i*128 +: 128]; symbol 0 in the MSByte
ts_cnt  out  CNT_W  accepted beats since last load
ts_sent_enough  out  1  ts_cnt >= captured target
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync deassert): all outputs 0, state IDLE, config registers 0.
- Symbol map per lane i:
  - sym0 = 8'hBC (COM).
  - sym1 = link_pad ? 8'hF7 : link_num.
  - sym2 = lane_pad ? 8'hF7 : i[7:0].
  - sym3 = 8'hFF.
  - sym4 = {2'b00, rate_support}.
  - sym5 = 8'h00.
  - sym6..15 = 8'h4A for TS1, 8'h45 for TS2.
- Config, including ts_target, is captured only at load; inputs are ignored otherwise.
- Handshake: a beat is accepted when ts_valid & ts_ready.
  - While ts_valid=1 & ts_ready=0, ts and ts_valid hold stable.
  - ts_valid never drops without an accepted beat.
- States:
  - IDLE: ts_req -> load config, ts_cnt = 0, ts_sent_enough = 0, go to SEND. ts_valid=1 and ts valid on the next cycle (1-cycle latency).
  - SEND: ts_valid=1. On each accepted beat, ts_cnt += 1, saturating at all-ones.
    - ts_stop -> STOP_WAIT.
    - ts_req -> set pend_load.
    - On an accepted beat with pend_load: reload config, ts_cnt = 0, ts_sent_enough = 0, clear pend_load. This happens in the same cycle as the acceptance, and the new ts appears on the next cycle.
  - STOP_WAIT: ts_valid stays 1 until an accepted beat, which is counted; then ts_valid = 0 -> IDLE. If a beat is accepted in the same cycle ts_stop is seen, go directly to IDLE.
- ts_sent_enough is registered, set the cycle after ts_cnt >= target.
  - Target = 0 -> asserts one cycle after load.
  - Sticky until the next load.
  - In IDLE it retains its value.
- Simultaneous ts_req & ts_stop: ts_stop wins and ts_req is dropped; pend_load is cleared.
- ts_req in STOP_WAIT is ignored.
- Reset mid-beat: ts_valid drops immediately and the beat is lost; the beat is not counted.

Optional Feature:
TS_LANE_REVERSE_EN
- Defined: adds input port lane_rev (1 bit), captured at load. When the captured value is 1 and lane_pad = 0, sym2 of lane i = NUM_LANES-1-i.
- Undefined: port absent; sym2 = i.

Test Plan:
- NUM_LANES=4, ts_req with TS1, link_num=8'h05, lane_pad=0, rate_support=6'h03, ready=1 -> next cycle lane2 = BC 05 02 FF 03 00 followed by ten 4A; lane3 sym2 = 03.
- ts_target=16, ready toggling 1/0 every cycle -> ts stable during stalls; ts_cnt reaches 16 after 16 accepts; ts_sent_enough rises exactly one cycle later.
- In SEND with ready=0, pulse ts_stop -> ts_valid stays 1; on first ready=1 the beat is counted, ts_valid=0 next cycle, busy=0.
- In SEND, ts_req with TS2 and target=2 while ready=0, then ready=1 -> old TS1 beat accepted, ts_cnt=0, next beat carries 45 in sym6..15, ts_sent_enough=0 until 2 further accepts.
- ts_req & ts_stop same cycle in SEND -> stop only; return to IDLE, no reload. Target=0 load -> ts_sent_enough=1 one cycle after load.
- Assert rst_n=0 mid-stall -> ts_valid, ts_cnt, ts_sent_enough = 0 immediately, without a clock edge.
